blockram_fifo: RTL

Show-ahead synchronous FIFO that drives both ports of `dual_port_blockram`. It is the writer on the RAM write port and the reader on the RAM read port, turning the raw one-cycle-latency RAM into a ready/valid queue. It sits between pipeline stages that need deep buffering backed by block RAM, for example fetch and miss queues. A two-entry output stage hides the RAM read latency and sustains one pop per cycle.

---
 rtl/blockram_fifo_pkg.sv | 17 +
 rtl/blockram_fifo_dual_port_blockram.sv | 72 +++++++
 rtl/blockram_fifo.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/blockram_fifo_pkg.sv
// Shared constants and helpers for blockram_fifo and its block RAM.
package blockram_fifo_pkg;

  localparam int unsigned BYTE_LEN_IN_BITS = 8;

  // Read data appears one cycle after the read is issued.
  localparam int unsigned RamReadLatencyCycles = 1;

  // Output stage depth; two entries are enough to hide the RAM read latency.
  localparam int unsigned StageDepth = 2;

  // Number of byte lanes in one entry.
  function automatic int unsigned write_mask_len(input int unsigned entry_bits);
    return entry_bits / BYTE_LEN_IN_BITS;
  endfunction

endpackage

// File: rtl/blockram_fifo_dual_port_blockram.sv
// Simple dual-port block RAM: one byte-masked write port and one read port with
// registered data and a matching valid. CONFIG_MODE selects "ReadFirst" (old
// data on same-address collision) or "WriteFirst" (new data forwarded).
module dual_port_blockram
  import blockram_fifo_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned NUM_SET                    = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int unsigned WRITE_MASK_LEN = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS,
  parameter string       CONFIG_MODE                = "ReadFirst"
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic                                  read_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      read_set_addr_in,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_port_data_out,
  output logic                                  read_port_valid_out,
  input  logic                                  write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      write_set_addr_in,
  input  logic [WRITE_MASK_LEN-1:0]             write_mask_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_port_data_in
);

  localparam bit WriteFirst = (CONFIG_MODE == "WriteFirst");

  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem [NUM_SET];
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] rd_data_d, rd_data_q;
  logic                                  rd_valid_q;

  // Byte-masked array write; the array itself is never reset.
  always_ff @(posedge clk_in) begin
    if (write_en_in) begin
      for (int b = 0; b < int'(WRITE_MASK_LEN); b++) begin
        if (write_mask_in[b]) begin
          mem[write_set_addr_in][b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] <=
            write_port_data_in[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
        end
      end
    end
  end

  // Array read word, with same-address forwarding only in write-first mode.
  always_comb begin
    rd_data_d = mem[read_set_addr_in];
    if (WriteFirst && write_en_in && (write_set_addr_in == read_set_addr_in)) begin
      for (int b = 0; b < int'(WRITE_MASK_LEN); b++) begin
        if (write_mask_in[b]) begin
          rd_data_d[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] =
            write_port_data_in[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
        end
      end
    end
  end

  // Registered read data and valid.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= read_en_in;
      if (read_en_in) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign read_port_data_out  = rd_data_q;
  assign read_port_valid_out = rd_valid_q;

endmodule

// File: rtl/blockram_fifo.sv
// Show-ahead ready/valid FIFO backed by dual_port_blockram, with a two-entry
// output stage hiding the RAM read latency. Optional feature macro:
// BLOCKRAM_FIFO_ALMOST_FULL_EN adds ALMOST_FULL_THRESHOLD and almost_full_out.
module blockram_fifo
  import blockram_fifo_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned NUM_SET                    = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET)
`ifdef BLOCKRAM_FIFO_ALMOST_FULL_EN
  ,
  parameter int unsigned ALMOST_FULL_THRESHOLD      = NUM_SET - 4
`endif
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic                                  push_valid_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] push_data_in,
  output logic                                  push_ready_out,
  output logic                                  pop_valid_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] pop_data_out,
  input  logic                                  pop_ready_in,
  output logic [SET_PTR_WIDTH_IN_BITS+1:0]      occupancy_out
`ifdef BLOCKRAM_FIFO_ALMOST_FULL_EN
  ,
  output logic                                  almost_full_out
`endif
);

  localparam int unsigned W       = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int unsigned PW      = SET_PTR_WIDTH_IN_BITS;
  localparam int unsigned OccW    = PW + 2;
  localparam int unsigned MaskLen = write_mask_len(W);

  localparam logic [PW:0]   NumSetOcc = (PW+1)'(NUM_SET);
  localparam logic [PW-1:0] PtrMax    = PW'(NUM_SET - 1);

  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [PW:0]   ram_occ_d, ram_occ_q;
  logic          inflight_d, inflight_q;
  logic [1:0]    stage_cnt_d, stage_cnt_q;
  logic [W-1:0]  head_d, head_q;
  logic [W-1:0]  tail_d, tail_q;

  logic          push, pop, rd_issue, capture;
  logic [W-1:0]  ram_rd_data;
  logic          ram_rd_valid;

  dual_port_blockram #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(W),
    .NUM_SET                   (NUM_SET),
    .SET_PTR_WIDTH_IN_BITS     (PW),
    .WRITE_MASK_LEN            (MaskLen),
    .CONFIG_MODE               ("ReadFirst")
  ) u_ram (
    .clk_in             (clk_in),
    .reset_in           (~reset_in),
    .read_en_in         (rd_issue),
    .read_set_addr_in   (rd_ptr_q),
    .read_port_data_out (ram_rd_data),
    .read_port_valid_out(ram_rd_valid),
    .write_en_in        (push),
    .write_set_addr_in  (wr_ptr_q),
    .write_mask_in      ({MaskLen{1'b1}}),
    .write_port_data_in (push_data_in)
  );

  // Handshakes, read issue and RAM-side pointer/occupancy next state.
  always_comb begin
    push_ready_out = reset_in && (ram_occ_q != NumSetOcc);
    pop_valid_out  = (stage_cnt_q != 2'd0);
    push           = push_valid_in && push_ready_out;
    pop            = pop_valid_out && pop_ready_in;
    capture        = ram_rd_valid && inflight_q;
    // ram_occ_q lags a push by one cycle, so the read address never equals a
    // same-cycle write address.
    rd_issue = (ram_occ_q != '0) &&
               (({1'b0, stage_cnt_q} + {2'b0, inflight_q}) < (3'(StageDepth) + {2'b0, pop}));

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (rd_issue) begin
      rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
    end

    ram_occ_d = ram_occ_q;
    if (push && !rd_issue) begin
      ram_occ_d = ram_occ_q + 1'b1;
    end else if (!push && rd_issue) begin
      ram_occ_d = ram_occ_q - 1'b1;
    end

    inflight_d = inflight_q;
    if (rd_issue) begin
      inflight_d = 1'b1;
    end else if (capture) begin
      inflight_d = 1'b0;
    end
  end

  // Output stage next state: head feeds pop_data_out, tail holds the second entry.
  always_comb begin
    stage_cnt_d = stage_cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    if (capture && !pop) begin
      stage_cnt_d = stage_cnt_q + 2'd1;
      if (stage_cnt_q == 2'd0) begin
        head_d = ram_rd_data;
      end else begin
        tail_d = ram_rd_data;
      end
    end else if (pop && !capture) begin
      stage_cnt_d = stage_cnt_q - 2'd1;
      if (stage_cnt_q == 2'd2) begin
        head_d = tail_q;
      end
    end else if (pop && capture) begin
      if (stage_cnt_q == 2'd2) begin
        head_d = tail_q;
        tail_d = ram_rd_data;
      end else begin
        head_d = ram_rd_data;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_occ_q   <= '0;
      inflight_q  <= 1'b0;
      stage_cnt_q <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_occ_q   <= ram_occ_d;
      inflight_q  <= inflight_d;
      stage_cnt_q <= stage_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  assign pop_data_out  = head_q;
  assign occupancy_out = OccW'(ram_occ_q) + OccW'(inflight_q) + OccW'(stage_cnt_q);

`ifdef BLOCKRAM_FIFO_ALMOST_FULL_EN
  logic almost_full_d, almost_full_q;

  // Threshold compare on current occupancy, registered for the output.
  always_comb begin
    almost_full_d = (occupancy_out >= OccW'(ALMOST_FULL_THRESHOLD));
  end

  // Almost-full flag register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full_out = almost_full_q;
`else
  // No almost-full tracking in this build.
`endif

endmodule
